mips_cpu_ifetch: RTL and testbench
==================================

Name: mips_cpu_ifetch

Overview:
Instruction fetch stage directly downstream of the PC unit. Takes the current PC and the PC unit's active flag, issues one 32-bit Avalon-MM read per instruction, and honours waitrequest. Holds the returned word for the decode stage with a valid/ack handshake. Drives a stall back to the PC unit so the PC holds while a fetch is outstanding or unconsumed.

Parameters:
MAX_WAIT, 255, waitrequest cycles tolerated within one transaction before bus_timeout sets
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pc_in  in  32  fetch address from the PC unit (pc_out)
active  in  1  PC unit active flag; fetches are issued only when high
fetch_en  in  1  request to fetch the instruction at pc_in
avm_address  out  32  Avalon read address
avm_read  out  1  Avalon read strobe
avm_byteenable  out  4  constant 4'hF
avm_waitrequest  in  1  Avalon wait
avm_readdata  in  32  Avalon read data
instr_out  out  32  fetched instruction
instr_valid  out  1  instr_out holds an unconsumed instruction
instr_ack  in  1  decode consumes instr_out this cycle
stall  out  1  PC unit must hold its PC
fetch_fault  out  1  sticky: misaligned fetch attempted
bus_timeout  out  1  sticky: waitrequest exceeded MAX_WAIT

Behaviour:
- Single clock domain. rst is synchronous active-high; all state updates on the rising clk edge.
- Reset values:
  - state IDLE
  - avm_read 0, avm_address 0
  - instr_out 0, instr_valid 0
  - fetch_fault 0, bus_timeout 0
  - wait counter 0
  - stall 0, because stall is derived from state
- Reset mid-transaction drops avm_read in the next cycle; no data is captured.
- FSM states:
  - IDLE: avm_read=0, instr_valid=0.
  - REQ: avm_read=1; avm_address is stable for the whole state.
  - VALID: instr_valid=1; instr_out is stable.
- issue condition = active && fetch_en && pc_in[1:0]==2'b00.
- IDLE transitions:
  - Issue condition true: avm_address<=pc_in, go to REQ, wait counter <=0.
  - active && fetch_en && pc_in[1:0]!=0: fetch_fault<=1, stay in IDLE, no bus access.
- REQ transitions:
  - Edge with avm_waitrequest=0 and active=1: instr_out<=avm_readdata, go to VALID.
  - Edge with avm_waitrequest=0 and active=0: discard the data, go to IDLE.
  - Edge with avm_waitrequest=1: stay in REQ, wait counter saturating-increments.
  - When the counter equals MAX_WAIT, bus_timeout<=1. The read stays asserted; Avalon reads are never aborted.
- VALID transitions:
  - active=0: go to IDLE; instr_valid drops the next cycle.
  - instr_ack=1 with the issue condition true: back-to-back fetch, go directly to REQ with the new pc_in.
  - instr_ack=1 otherwise: go to IDLE.
  - instr_ack=0: hold instr_out and instr_valid unchanged.
- Misaligned pc_in seen in VALID on an ack also sets fetch_fault and goes to IDLE.
- stall (combinational) = (state==REQ) || (state==VALID && !instr_ack).
- Latency: issue at edge N puts avm_read high from N; with zero waitrequest, instr_valid is high after edge N+1. A fetch takes 2 cycles minimum; k wait cycles add k.
- A simultaneous ack and new issue in VALID gives no bubble on avm_read: read re-asserted with the new address in the next cycle.
- Sticky flags clear only on rst.

Optional Feature:
MIPS_IFETCH_BYTESWAP_EN
- Defined: instr_out captures {rd[7:0],rd[15:8],rd[23:16],rd[31:24]} of avm_readdata, converting big-endian instruction words stored in the little-endian memory.
- Undefined: avm_readdata is captured unchanged.
- The option does not change any timing.

Test Plan:
1. Reset, then active=1, fetch_en=1, pc_in=32'hBFC00000, waitrequest=0, readdata=32'h24020005 -> avm_read high 1 cycle with address BFC00000; instr_valid next cycle with instr_out 24020005 (05000224 with BYTESWAP_EN); stall=1 while in REQ.
2. Same fetch with waitrequest held high 3 cycles -> avm_read and address stable 4 cycles; instr_valid 1 cycle after waitrequest falls; bus_timeout stays 0.
3. instr_ack=0 for 5 cycles in VALID -> instr_out stable, stall=1; on ack with fetch_en and pc_in=BFC00004 -> next cycle avm_read=1 with address BFC00004, no idle cycle.
4. pc_in=32'hBFC00002, fetch_en=1 -> no avm_read, fetch_fault=1 after the edge and stays 1 until rst.
5. MAX_WAIT=4, waitrequest high 10 cycles -> bus_timeout=1 after the 4th wait edge; read is still held; completes normally when waitrequest falls.
6. active=0 during REQ, then waitrequest falls -> instr_valid never rises, state IDLE; rst asserted in REQ -> avm_read=0 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch stage: one Avalon-MM read per instruction, valid/ack to decode.
// Optional: define MIPS_IFETCH_BYTESWAP_EN to byte-swap fetched words.
module mips_cpu_ifetch #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        active,
    input  logic        fetch_en,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        stall,
    output logic        fetch_fault,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             want;
    logic             issue;
    logic             misaligned;

    // Memory holds big-endian words when the swap option is built in.
    function automatic logic [31:0] fmt_word(input logic [31:0] d);
`ifdef MIPS_IFETCH_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    assign avm_byteenable = 4'hF;

    // Decode the fetch request and the saturating wait count.
    always_comb begin
        want          = active && fetch_en;
        issue         = want && (pc_in[1:0] == 2'b00);
        misaligned    = want && (pc_in[1:0] != 2'b00);
        wait_cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    end

    // PC must hold while a read is in flight or a word is unconsumed.
    always_comb begin
        stall = (state == REQ) || ((state == VALID) && !instr_ack);
    end

    // Fetch FSM with registered bus and decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 32'h0;
            instr_out   <= 32'h0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            bus_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        avm_address <= pc_in;
                        avm_read    <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= REQ;
                    end else if (misaligned) begin
                        fetch_fault <= 1'b1;
                    end
                end
                REQ: begin
                    // Avalon reads cannot be aborted; wait it out.
                    if (avm_waitrequest) begin
                        wait_cnt <= wait_cnt_next;
                        if (wait_cnt_next >= MAX_CNT) begin
                            bus_timeout <= 1'b1;
                        end
                    end else begin
                        avm_read <= 1'b0;
                        if (active) begin
                            instr_out   <= fmt_word(avm_readdata);
                            instr_valid <= 1'b1;
                            state       <= VALID;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                VALID: begin
                    if (!active) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (issue) begin
                            avm_address <= pc_in;
                            avm_read    <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= REQ;
                        end else begin
                            if (misaligned) begin
                                fetch_fault <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    avm_read    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Scoreboard bench for mips_cpu_ifetch (MAX_WAIT=4).
// Expected words are queued when read data is presented and popped on instr_valid.
module tb_mips_cpu_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        active;
    logic        fetch_en;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ack;
    logic        stall;
    logic        fetch_fault;
    logic        bus_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    mips_cpu_ifetch #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .active(active),
        .fetch_en(fetch_en), .avm_address(avm_address),
        .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .stall(stall),
        .fetch_fault(fetch_fault), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d);
`ifdef MIPS_IFETCH_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] d);
        avm_readdata = d;
        exp_q.push_back(model(d));
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            exp_w = 32'hDEADDEAD;
        end else begin
            exp_w = exp_q.pop_front();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; active = 1'b0; fetch_en = 1'b0; pc_in = 32'h0;
        avm_waitrequest = 1'b0; avm_readdata = 32'h0; instr_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic consume();
        instr_ack = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL ack_stall got %b want 0", stall);
        end
        tick();
        instr_ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL ack_drop got %b want 0", instr_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({avm_read, instr_valid, stall, fetch_fault, bus_timeout} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_flags got %b want 00000",
                     {avm_read, instr_valid, stall, fetch_fault, bus_timeout});
        end
        n_cmp++;
        if ({avm_address, instr_out} !== 64'h0) begin
            n_bad++; $display("FAIL rst_regs got %h/%h want 0/0", avm_address, instr_out);
        end
        n_cmp++;
        if (avm_byteenable !== 4'hF) begin
            n_bad++; $display("FAIL byteen got %h want f", avm_byteenable);
        end
    endtask

    task automatic test_single();
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00000;
        avm_waitrequest = 1'b0;
        present(32'h24020005);
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if ({avm_read, stall, instr_valid} !== 3'b110 || avm_address !== 32'hBFC00000) begin
            n_bad++;
            $display("FAIL single_req got rd=%b st=%b v=%b a=%h want 1 1 0 bfc00000",
                     avm_read, stall, instr_valid, avm_address);
        end
        tick();
        pop_exp();
        n_cmp++;
        if ({avm_read, instr_valid, stall} !== 3'b011 || instr_out !== exp_w) begin
            n_bad++;
            $display("FAIL single_data got rd=%b v=%b st=%b i=%h want 0 1 1 %h",
                     avm_read, instr_valid, stall, instr_out, exp_w);
        end
        consume();
    endtask

    task automatic test_wait();
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00000;
        avm_waitrequest = 1'b1;
        present(32'h8C880000);
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (avm_read !== 1'b1 || avm_address !== 32'hBFC00000 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_hold[%0d] got rd=%b a=%h v=%b want 1 bfc00000 0",
                         i, avm_read, avm_address, instr_valid);
            end
            if (i < 3) tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        pop_exp();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== exp_w || bus_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_done got v=%b i=%h to=%b want 1 %h 0",
                     instr_valid, instr_out, bus_timeout, exp_w);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00000;
        avm_waitrequest = 1'b0;
        present(32'h3C1DA000);
        tick();
        fetch_en = 1'b0;
        tick();
        pop_exp();
        held = exp_w;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_out !== held || stall !== 1'b1) begin
                n_bad++;
                $display("FAIL hold[%0d] got v=%b i=%h st=%b want 1 %h 1",
                         i, instr_valid, instr_out, stall, held);
            end
            tick();
        end
        instr_ack = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00004;
        present(32'h27BD0010);
        tick();
        instr_ack = 1'b0; fetch_en = 1'b0;
        n_cmp++;
        if (avm_read !== 1'b1 || avm_address !== 32'hBFC00004 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_req got rd=%b a=%h v=%b want 1 bfc00004 0",
                     avm_read, avm_address, instr_valid);
        end
        tick();
        pop_exp();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== exp_w) begin
            n_bad++;
            $display("FAIL b2b_data got v=%b i=%h want 1 %h", instr_valid, instr_out, exp_w);
        end
        consume();
    endtask

    task automatic test_misaligned();
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00002;
        tick();
        fetch_en = 1'b0;
        n_cmp++;
        if (avm_read !== 1'b0 || fetch_fault !== 1'b1 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign got rd=%b ff=%b st=%b want 0 1 0",
                     avm_read, fetch_fault, stall);
        end
        tick(); tick();
        n_cmp++;
        if (fetch_fault !== 1'b1 || avm_read !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_sticky got ff=%b rd=%b want 1 0", fetch_fault, avm_read);
        end
    endtask

    task automatic test_timeout();
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00008;
        avm_waitrequest = 1'b1;
        present(32'h00000000);
        tick();
        fetch_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (bus_timeout !== (k >= 4) || avm_read !== 1'b1) begin
                n_bad++;
                $display("FAIL timeout[%0d] got to=%b rd=%b want %b 1",
                         k, bus_timeout, avm_read, (k >= 4));
            end
        end
        avm_waitrequest = 1'b0;
        tick();
        pop_exp();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== exp_w || bus_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_done got v=%b i=%h to=%b want 1 %h 1",
                     instr_valid, instr_out, bus_timeout, exp_w);
        end
        consume();
    endtask

    task automatic test_abort();
        do_reset();
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC0000C;
        avm_waitrequest = 1'b1; avm_readdata = 32'h11111111;
        tick();
        fetch_en = 1'b0; active = 1'b0;
        tick();
        avm_waitrequest = 1'b0;
        tick();
        n_cmp++;
        if ({avm_read, instr_valid, stall} !== 3'b000) begin
            n_bad++;
            $display("FAIL drop got rd=%b v=%b st=%b want 000", avm_read, instr_valid, stall);
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
            n_bad++; $display("FAIL drop_idle got v=%b i=%h want 0 0", instr_valid, instr_out);
        end
        active = 1'b1; fetch_en = 1'b1; pc_in = 32'hBFC00010;
        avm_waitrequest = 1'b1;
        tick();
        n_cmp++;
        if (avm_read !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre got rd=%b want 1", avm_read);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; active = 1'b0; fetch_en = 1'b0; avm_waitrequest = 1'b0;
        n_cmp++;
        if ({avm_read, instr_valid, stall, fetch_fault, bus_timeout} !== 5'b0 ||
            avm_address !== 32'h0 || instr_out !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid got rd=%b v=%b st=%b a=%h i=%h want all zero",
                     avm_read, instr_valid, stall, avm_address, instr_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wait();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_abort();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
